// File: rtl/saturating_narrower.sv
// rtl/saturating_narrower.sv - registered signed-width reducer with saturate/wrap and overflow status
module saturating_narrower #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    wrap_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_ovf,
  output logic                    ovf_sticky,
  output logic [COUNT_WIDTH-1:0]  ovf_count,
  input  logic                    clear
);

  localparam logic [OUTPUT_WIDTH-1:0] SAT_MAX   = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] SAT_MIN   = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0]  COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0]  COUNT_ONE = COUNT_WIDTH'(1);

  // Bits that must all equal the output sign bit for the sample to fit.
  logic [INPUT_WIDTH-OUTPUT_WIDTH:0] top_bits;
  logic                              ovf;
  logic [OUTPUT_WIDTH-1:0]           narrowed;
  logic                              in_xfer;
  logic                              out_xfer;
  logic                              ovf_event;

  assign top_bits  = in_data[INPUT_WIDTH-1:OUTPUT_WIDTH-1];
  assign ovf       = ~((&top_bits) | ~(|top_bits));
  assign in_ready  = ~out_valid | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign ovf_event = in_xfer & ovf;

  // Select truncated bits, or the clamp value in saturate mode when out of range.
  always_comb begin
    narrowed = in_data[OUTPUT_WIDTH-1:0];
    if (!wrap_mode && ovf) begin
      narrowed = in_data[INPUT_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Output stage: load on input transfer, drain valid on a lone output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= narrowed;
      out_ovf   <= ovf;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Overflow status: a same-cycle event wins over clear; the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clear) begin
      ovf_sticky <= ovf_event;
      ovf_count  <= ovf_event ? COUNT_ONE : '0;
    end else if (ovf_event) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != COUNT_MAX) begin
        ovf_count <= ovf_count + COUNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_saturating_narrower.sv
// tb/tb_saturating_narrower.sv - directed self-checking bench for saturating_narrower
module tb_saturating_narrower;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        wrap_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_ovf;
  logic        ovf_sticky;
  logic [15:0] ovf_count;
  logic        clear;

  logic        c2_in_ready;
  logic        c2_out_valid;
  logic [7:0]  c2_out_data;
  logic        c2_out_ovf;
  logic        c2_sticky;
  logic [1:0]  c2_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] xfer_q[$];

  always #5 clk = ~clk;

  saturating_narrower #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wrap_mode(wrap_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clear(clear)
  );

  saturating_narrower #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .COUNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_in_ready),
    .in_data(in_data), .wrap_mode(wrap_mode), .out_valid(c2_out_valid),
    .out_ready(out_ready), .out_data(c2_out_data), .out_ovf(c2_out_ovf),
    .ovf_sticky(c2_sticky), .ovf_count(c2_count), .clear(clear)
  );

  // Log every output handshake of the main instance.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) xfer_q.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; wrap_mode = 1'b0;
    out_ready = 1'b1; clear = 1'b0;
    tick();
    tick();
    tests++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %0b want 1", in_ready); fails++; end
    tests++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %0b want 0", out_valid); fails++; end
    tests++; if (out_data !== 8'h00) begin $display("FAIL reset_out_data got %h want 00", out_data); fails++; end
    tests++; if (out_ovf !== 1'b0) begin $display("FAIL reset_out_ovf got %0b want 0", out_ovf); fails++; end
    tests++; if (ovf_sticky !== 1'b0) begin $display("FAIL reset_sticky got %0b want 0", ovf_sticky); fails++; end
    tests++; if (ovf_count !== 16'd0) begin $display("FAIL reset_count got %0d want 0", ovf_count); fails++; end
    rst_n = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1) begin $display("FAIL post_reset_in_ready got %0b want 1", in_ready); fails++; end
  endtask

  task automatic test_saturate();
    logic [15:0] vin  [5] = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h8000};
    logic [7:0]  vout [5] = '{8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80};
    logic        vovf [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    wrap_mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = vin[i];
      tick();
      tests++; if (out_valid !== 1'b1) begin $display("FAIL sat_valid[%0d] got %0b want 1", i, out_valid); fails++; end
      tests++; if (out_data !== vout[i]) begin $display("FAIL sat_data[%0d] got %h want %h", i, out_data, vout[i]); fails++; end
      tests++; if (out_ovf !== vovf[i]) begin $display("FAIL sat_ovf[%0d] got %0b want %0b", i, out_ovf, vovf[i]); fails++; end
    end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin $display("FAIL sat_drain got %0b want 0", out_valid); fails++; end
    tests++; if (ovf_count !== 16'd3) begin $display("FAIL sat_count got %0d want 3", ovf_count); fails++; end
    tests++; if (ovf_sticky !== 1'b1) begin $display("FAIL sat_sticky got %0b want 1", ovf_sticky); fails++; end
  endtask

  task automatic test_wrap();
    logic [15:0] vin  [2] = '{16'h0180, 16'hFE7F};
    logic [7:0]  vout [2] = '{8'h80, 8'h7F};
    do_clear();
    wrap_mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = vin[i];
      tick();
      tests++; if (out_data !== vout[i]) begin $display("FAIL wrap_data[%0d] got %h want %h", i, out_data, vout[i]); fails++; end
      tests++; if (out_ovf !== 1'b1) begin $display("FAIL wrap_ovf[%0d] got %0b want 1", i, out_ovf); fails++; end
    end
    in_valid = 1'b0; wrap_mode = 1'b0;
    tick();
    tests++; if (ovf_count !== 16'd2) begin $display("FAIL wrap_count got %0d want 2", ovf_count); fails++; end
  endtask

  task automatic test_backpressure();
    xfer_q.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0012;
    tick();
    out_ready = 1'b0; in_data = 16'h0034;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); fails++; end
      tests++; if (out_data !== 8'h12 || out_valid !== 1'b1) begin
        $display("FAIL bp_hold[%0d] got valid=%0b data=%h want valid=1 data=12", i, out_valid, out_data); fails++; end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready got %0b want 1", in_ready); fails++; end
    tick();
    in_valid = 1'b0;
    tests++; if (out_data !== 8'h34 || out_valid !== 1'b1) begin
      $display("FAIL bp_next got valid=%0b data=%h want valid=1 data=34", out_valid, out_data); fails++; end
    tick();
    tests++; if (xfer_q.size() !== 2) begin $display("FAIL bp_xfer_count got %0d want 2", xfer_q.size()); fails++; end
    else begin
      tests++; if (xfer_q[0] !== 8'h12 || xfer_q[1] !== 8'h34) begin
        $display("FAIL bp_xfer_order got %h,%h want 12,34", xfer_q[0], xfer_q[1]); fails++; end
    end
  endtask

  task automatic test_count_saturation();
    logic [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_clear();
    out_ready = 1'b1; wrap_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 16'h4000;
      tick();
      tests++; if (c2_count !== exp_cnt[i]) begin $display("FAIL cnt_sat[%0d] got %0d want %0d", i, c2_count, exp_cnt[i]); fails++; end
    end
    in_valid = 1'b0;
    tests++; if (ovf_count !== 16'd6) begin $display("FAIL cnt_wide got %0d want 6", ovf_count); fails++; end
    clear = 1'b1;
    tick();
    tests++; if (c2_count !== 2'd0 || c2_sticky !== 1'b0) begin
      $display("FAIL clear_idle got count=%0d sticky=%0b want count=0 sticky=0", c2_count, c2_sticky); fails++; end
    tests++; if (ovf_count !== 16'd0 || ovf_sticky !== 1'b0) begin
      $display("FAIL clear_idle_wide got count=%0d sticky=%0b want count=0 sticky=0", ovf_count, ovf_sticky); fails++; end
    in_valid = 1'b1; in_data = 16'h8000;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    tests++; if (c2_count !== 2'd1 || c2_sticky !== 1'b1) begin
      $display("FAIL clear_event got count=%0d sticky=%0b want count=1 sticky=1", c2_count, c2_sticky); fails++; end
    tests++; if (ovf_count !== 16'd1 || ovf_sticky !== 1'b1) begin
      $display("FAIL clear_event_wide got count=%0d sticky=%0b want count=1 sticky=1", ovf_count, ovf_sticky); fails++; end
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      $display("FAIL mid_held got valid=%0b data=%h want valid=1 data=55", out_valid, out_data); fails++; end
    tick();
    xfer_q.delete();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 1'b0) begin
      $display("FAIL mid_async_out got valid=%0b data=%h ovf=%0b want 0,00,0", out_valid, out_data, out_ovf); fails++; end
    tests++; if (ovf_sticky !== 1'b0 || ovf_count !== 16'd0 || in_ready !== 1'b1) begin
      $display("FAIL mid_async_status got sticky=%0b count=%0d ready=%0b want 0,0,1", ovf_sticky, ovf_count, in_ready); fails++; end
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin $display("FAIL mid_post_valid got %0b want 0", out_valid); fails++; end
    in_valid = 1'b1; in_data = 16'h0003;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin
      $display("FAIL mid_latency got valid=%0b data=%h want valid=1 data=03", out_valid, out_data); fails++; end
    tick();
    tests++; if (xfer_q.size() !== 1) begin $display("FAIL mid_xfer_count got %0d want 1", xfer_q.size()); fails++; end
    else begin
      tests++; if (xfer_q[0] !== 8'h03) begin $display("FAIL mid_xfer_data got %h want 03", xfer_q[0]); fails++; end
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_wrap();
    test_backpressure();
    test_count_saturation();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
